// File: rtl/dispatch_queue_pkg.sv
// Shared types for the decode -> reservation-station dispatch queue.
// Holds the control word layout, the op encoding and parameter limits.
package dispatch_queue_pkg;

  localparam int DQ_MAX_DEPTH = 64;
  localparam int DQ_MAX_RS    = 16;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALU    = 3'd1,
    OP_SHIFT  = 3'd2,
    OP_MUL    = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_LOAD   = 3'd6,
    OP_STORE  = 3'd7
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } ctl_word;

  // Loads and stores go to the load/store station; everything else to an ALU station.
  function automatic logic is_mem_op(input op_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/dispatch_queue_rs_select.sv
// ALU reservation-station selector: request vector in, one-hot grant out.
// Default build: lowest-index requester wins.
// With DISPATCH_RR_EN defined: rotating priority pointer, advanced past the
// granted index whenever advance_i is high.
module rs_select
  import dispatch_queue_pkg::*;
#(
  parameter int NUM_RS = 4
) (
`ifdef DISPATCH_RR_EN
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
`endif
  input  logic [NUM_RS-1:0] req_i,
  output logic [NUM_RS-1:0] gnt_o
);

  if (NUM_RS < 1 || NUM_RS > DQ_MAX_RS) begin : g_bad_num_rs
    $error("rs_select: NUM_RS out of range");
  end

`ifdef DISPATCH_RR_EN
  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;
  int               idx;

  // Search starting at the pointer, wrapping past NUM_RS-1 back to 0.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_RS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  // Pointer moves to one past the granted station, only on an actual ALU dispatch.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(gnt_idx) == NUM_RS - 1) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Pointer register; cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic found;

  // Fixed priority: first set bit from index 0 upward.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the reservation stations.
// Circular FIFO of DEPTH control words; the head is dispatched to one ALU
// station or to the load/store station, with a ROB allocate in the same cycle.
// Optional macro DISPATCH_RR_EN selects round-robin ALU station arbitration.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_RS = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  input  ctl_word           enq_ctl_i,
  output logic              enq_ready_o,
  input  logic [NUM_RS-1:0] rs_free_i,
  input  logic              ldst_rs_free_i,
  input  logic              rob_full_i,
  input  logic              ldst_q_full_i,
  output logic [NUM_RS-1:0] rs_load_o,
  output logic              ldst_load_o,
  output logic              rob_load_o,
  output ctl_word           deq_ctl_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > DQ_MAX_DEPTH) begin : g_bad_depth
    $error("dispatch_queue: DEPTH out of range");
  end

  ctl_word          mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  ctl_word          head_ctl;
  logic             head_is_mem;
  logic             disp_ok;
  logic             mem_fire;
  logic             alu_fire;
  logic             enq_fire;
  logic             deq_fire;
  logic [NUM_RS-1:0] alu_gnt;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_ctl = mem_q[head_q];

  rs_select #(
    .NUM_RS (NUM_RS)
  ) u_rs_select (
`ifdef DISPATCH_RR_EN
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (alu_fire),
`endif
    .req_i     (rs_free_i),
    .gnt_o     (alu_gnt)
  );

  // Dispatch decision on the registered head; a stalled head blocks everything behind it.
  always_comb begin
    head_is_mem = is_mem_op(head_ctl.op);
    disp_ok     = (count_q != '0) && !flush_i;
    mem_fire    = disp_ok && head_is_mem && ldst_rs_free_i && !rob_full_i && !ldst_q_full_i;
    alu_fire    = disp_ok && !head_is_mem && (|rs_free_i) && !rob_full_i;
  end

  // Enqueue acceptance uses registered occupancy only: a full queue stays full this cycle.
  assign enq_ready_o = (count_q != CNT_W'(DEPTH)) && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = mem_fire || alu_fire;

  assign rs_load_o   = alu_fire ? alu_gnt : '0;
  assign ldst_load_o = mem_fire;
  assign rob_load_o  = deq_fire;
  assign deq_ctl_o   = head_ctl;
  assign count_o     = count_q;

  // Pointer and occupancy next state; flush empties the queue without touching storage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = wrap_inc(tail_q);
      if (deq_fire) head_d = wrap_inc(head_q);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[tail_q] <= enq_ctl_i;
  end

  a_rs_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rs_load_o));
  a_rob_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    rob_load_o == ((|rs_load_o) || ldst_load_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_W'(DEPTH));

endmodule
